// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: drives one column low per 4-clock slot, synchronizes the rows,
// debounces whole-scan results and emits a one-clock pulse per new key press.
module keypad_scanner #(
    parameter int unsigned DEBOUNCE_SCANS = 2
) (
    input  logic       clk_480Hz,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic       key_valid
);

    localparam logic [2:0] DbTarget = 3'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        StCol0 = 2'd0,
        StCol1 = 2'd1,
        StCol2 = 2'd2,
        StCol3 = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  row_meta_q, row_s_q;
    logic [3:0]  slice_q [4];
    logic [4:0]  prev_q, prev_d;
    logic [4:0]  result;
    logic [2:0]  stable_q, stable_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_down_q, key_down_d;
    logic        key_valid_q, key_valid_d;
    logic        capture, scan_end;
    logic [15:0] all_rows;
    logic [4:0]  n_keys;
    logic [3:0]  hit_code;

    // idx = {column, row}
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'h0: code = 4'h1;
            4'h1: code = 4'h4;
            4'h2: code = 4'h7;
            4'h3: code = 4'h0;
            4'h4: code = 4'h2;
            4'h5: code = 4'h5;
            4'h6: code = 4'h8;
            4'h7: code = 4'hF;
            4'h8: code = 4'h3;
            4'h9: code = 4'h6;
            4'hA: code = 4'h9;
            4'hB: code = 4'hE;
            4'hC: code = 4'hA;
            4'hD: code = 4'hB;
            4'hE: code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 2'd1;
        capture = (phase_q == 2'd3);
        if (capture) begin
            case (state_q)
                StCol0:  state_d = StCol1;
                StCol1:  state_d = StCol2;
                StCol2:  state_d = StCol3;
                StCol3:  state_d = StCol0;
                default: state_d = StCol0;
            endcase
        end
    end

    assign scan_end = capture && (state_q == StCol3);

    always_comb begin
        col = 4'b1110;
        case (state_q)
            StCol1:  col = 4'b1101;
            StCol2:  col = 4'b1011;
            StCol3:  col = 4'b0111;
            default: col = 4'b1110;
        endcase
    end

    // Column 3 is captured on the same edge the scan is evaluated, so use row_s directly.
    always_comb begin
        all_rows = {row_s_q, slice_q[2], slice_q[1], slice_q[0]};
        n_keys   = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (!all_rows[i]) begin
                n_keys   = n_keys + 5'd1;
                hit_code = key_map(4'(i));
            end
        end
        result = (n_keys == 5'd1) ? {1'b1, hit_code} : 5'b0_0000;
    end

    always_comb begin
        prev_d      = prev_q;
        stable_d    = stable_q;
        key_code_d  = key_code_q;
        key_down_d  = key_down_q;
        key_valid_d = 1'b0;
        if (scan_end) begin
            prev_d = result;
            if (result != prev_q) begin
                stable_d = 3'd1;
            end else if (stable_q >= DbTarget) begin
                stable_d = DbTarget;
            end else begin
                stable_d = stable_q + 3'd1;
            end
            if (stable_d == DbTarget) begin
                if (!result[4]) begin
                    key_down_d = 1'b0;
                end else if (!key_down_q || (key_code_q != result[3:0])) begin
                    key_code_d  = result[3:0];
                    key_down_d  = 1'b1;
                    key_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_480Hz) begin
        if (!reset) begin
            state_q     <= StCol0;
            phase_q     <= 2'd0;
            row_meta_q  <= 4'hF;
            row_s_q     <= 4'hF;
            for (int c = 0; c < 4; c++) begin
                slice_q[c] <= 4'hF;
            end
            prev_q      <= 5'b0_0000;
            stable_q    <= 3'd0;
            key_code_q  <= 4'h0;
            key_down_q  <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            row_meta_q  <= row;
            row_s_q     <= row_meta_q;
            if (capture) begin
                slice_q[state_q] <= row_s_q;
            end
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_down_q  <= key_down_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_down  = key_down_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: combinational keypad model, scan-level debounce
// model feeding a pulse scoreboard, plus fixed-latency checks.
module tb_keypad_scanner;

    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pressed;  // bit r*4+c set when key (r,c) is held
    logic [3:0]  row, col, key_code;
    logic        key_down, key_valid;
    logic [3:0]  row1, col1, key_code1;
    logic        key_down1, key_valid1;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  keymap [16];
    logic [3:0]  sb [$];
    logic [4:0]  m_prev;
    int          m_cnt;
    logic [3:0]  m_code;
    logic        m_down;

    always #5 clk = ~clk;

    function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (p[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
        return r;
    endfunction

    assign row  = keypad_rows(pressed, col);
    assign row1 = keypad_rows(pressed, col1);

    keypad_scanner #(.DEBOUNCE_SCANS(DB)) dut (
        .clk_480Hz(clk), .reset(reset), .row(row), .col(col),
        .key_code(key_code), .key_down(key_down), .key_valid(key_valid)
    );

    keypad_scanner #(.DEBOUNCE_SCANS(1)) dut1 (
        .clk_480Hz(clk), .reset(reset), .row(row1), .col(col1),
        .key_code(key_code1), .key_down(key_down1), .key_valid(key_valid1)
    );

    task automatic model_reset();
        m_prev = 5'b0;
        m_cnt  = 0;
        m_code = 4'h0;
        m_down = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (col !== 4'b1110) begin
            errors++; $display("FAIL %s col: got %b want 1110", tag, col);
        end
        checks++;
        if (key_code !== 4'h0) begin
            errors++; $display("FAIL %s key_code: got %h want 0", tag, key_code);
        end
        checks++;
        if (key_down !== 1'b0) begin
            errors++; $display("FAIL %s key_down: got %b want 0", tag, key_down);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL %s key_valid: got %b want 0", tag, key_valid);
        end
    endtask

    // Leaves the bench at a negedge with reset just released: next posedge is scan clock 1.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        model_reset();
    endtask

    // One 16-clock scan with the given keys held from its start.
    task automatic run_scan(input logic [15:0] keys, output int npulse, output int pulse_step,
                            output logic [3:0] pulse_code);
        logic [4:0] res;
        logic [3:0] code, exp_code, exp_col;
        int         n;
        pressed = keys;
        n = 0;
        code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (keys[i]) begin
                n++;
                code = keymap[i];
            end
        end
        res = (n == 1) ? {1'b1, code} : 5'b0;
        if (res == m_prev) m_cnt = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
        else m_cnt = 1;
        m_prev = res;
        if (m_cnt == DB) begin
            if (!res[4]) begin
                m_down = 1'b0;
            end else if (!m_down || m_code != res[3:0]) begin
                m_code = res[3:0];
                m_down = 1'b1;
                sb.push_back(m_code);
            end
        end
        npulse = 0;
        pulse_step = 0;
        pulse_code = 4'h0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (col !== exp_col) begin
                errors++; $display("FAIL col step %0d: got %b want %b", k, col, exp_col);
            end
            if (key_valid === 1'b1) begin
                npulse++;
                pulse_step = k;
                pulse_code = key_code;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: unexpected key_valid at step %0d code %h, want none",
                             k, key_code);
                end else begin
                    exp_code = sb.pop_front();
                    if (key_code !== exp_code || k != 16) begin
                        errors++;
                        $display("FAIL scoreboard: pulse code %h at step %0d, want %h at step 16",
                                 key_code, k, exp_code);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: missing key_valid, got none want code %h", sb[0]);
            sb.delete();
        end
        checks++;
        if (key_down !== m_down) begin
            errors++; $display("FAIL key_down after scan: got %b want %b", key_down, m_down);
        end
        checks++;
        if (key_code !== m_code) begin
            errors++; $display("FAIL key_code after scan: got %h want %h", key_code, m_code);
        end
    endtask

    task automatic test_reset();
        int np, st, total;
        logic [3:0] pc;
        total = 0;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            run_scan(16'h0000, np, st, pc);
            total += np;
        end
        checks++;
        if (total != 0) begin
            errors++; $display("FAIL idle pulses: got %0d want 0", total);
        end
    endtask

    task automatic test_single_press();
        int np, st, total, at;
        logic [3:0] pc, code;
        total = 0; at = 0; code = 4'h0;
        do_reset();
        for (int s = 0; s < 10; s++) begin
            run_scan(16'h0020, np, st, pc);
            if (np > 0) begin
                at = s * 16 + st;
                code = pc;
            end
            total += np;
        end
        checks++;
        if (total != 1 || at != 32 || code !== 4'h5) begin
            errors++;
            $display("FAIL single_press: %0d pulses at clock %0d code %h, want 1 at 32 code 5",
                     total, at, code);
        end
        checks++;
        if (key_down !== 1'b1) begin
            errors++; $display("FAIL single_press key_down: got %b want 1", key_down);
        end
    endtask

    task automatic test_release_and_change();
        int np, st, total, at;
        logic [3:0] pc, code;
        total = 0;
        for (int s = 0; s < 2; s++) begin
            run_scan(16'h0000, np, st, pc);
            total += np;
        end
        checks++;
        if (total != 0 || key_down !== 1'b0 || key_code !== 4'h5) begin
            errors++;
            $display("FAIL release: pulses %0d key_down %b key_code %h, want 0 0 5",
                     total, key_down, key_code);
        end
        total = 0;
        for (int s = 0; s < 3; s++) begin
            run_scan(16'h0020, np, st, pc);
            total += np;
        end
        total = 0; at = -1; code = 4'h0;
        for (int s = 0; s < 3; s++) begin
            run_scan(16'h0040, np, st, pc);
            if (np > 0) begin
                at = s;
                code = pc;
            end
            total += np;
        end
        checks++;
        if (total != 1 || at != 1 || code !== 4'h6) begin
            errors++;
            $display("FAIL key_change: %0d pulses on scan %0d code %h, want 1 on scan 1 code 6",
                     total, at, code);
        end
    endtask

    task automatic test_bounce();
        int np, st, total, at;
        logic [3:0] pc, code;
        total = 0; at = -1; code = 4'h0;
        do_reset();
        run_scan(16'h0000, np, st, pc);
        total += np;
        for (int s = 0; s < 4; s++) begin
            run_scan((s % 2 == 0) ? 16'h8000 : 16'h0000, np, st, pc);
            total += np;
        end
        for (int s = 0; s < 5; s++) begin
            run_scan(16'h8000, np, st, pc);
            if (np > 0) begin
                at = s;
                code = pc;
            end
            total += np;
        end
        checks++;
        if (total != 1 || at != 1 || code !== 4'hD) begin
            errors++;
            $display("FAIL bounce: %0d pulses on hold scan %0d code %h, want 1 on scan 1 code D",
                     total, at, code);
        end
    endtask

    task automatic test_multi_key();
        int np, st, total;
        logic [3:0] pc, code;
        total = 0;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            run_scan(16'h0003, np, st, pc);
            total += np;
        end
        checks++;
        if (total != 0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL multi_key: %0d pulses key_down %b, want 0 and 0", total, key_down);
        end
        total = 0; code = 4'h0;
        for (int s = 0; s < 3; s++) begin
            run_scan(16'h0001, np, st, pc);
            if (np > 0) code = pc;
            total += np;
        end
        checks++;
        if (total != 1 || code !== 4'h1) begin
            errors++;
            $display("FAIL multi_key release: %0d pulses code %h, want 1 code 1", total, code);
        end
    endtask

    task automatic test_reset_mid();
        int np, st, total, at;
        logic [3:0] pc, code;
        do_reset();
        for (int s = 0; s < 3; s++) run_scan(16'h0400, np, st, pc);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (col !== 4'b1011) begin
            errors++; $display("FAIL mid_reset setup col: got %b want 1011", col);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("mid_reset");
        reset = 1'b1;
        model_reset();
        total = 0; at = 0; code = 4'h0;
        for (int s = 0; s < 3; s++) begin
            run_scan(16'h0400, np, st, pc);
            if (np > 0) begin
                at = s * 16 + st;
                code = pc;
            end
            total += np;
        end
        checks++;
        if (total != 1 || at != 32 || code !== 4'h9) begin
            errors++;
            $display("FAIL mid_reset: %0d pulses at clock %0d code %h, want 1 at 32 code 9",
                     total, at, code);
        end
    endtask

    task automatic test_debounce_one();
        int total, at;
        logic [3:0] code;
        total = 0; at = 0; code = 4'h0;
        do_reset();
        pressed = 16'h0020;
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid1 === 1'b1) begin
                total++;
                at = k;
                code = key_code1;
            end
        end
        checks++;
        if (total != 1 || at != 16 || code !== 4'h5 || key_down1 !== 1'b1) begin
            errors++;
            $display("FAIL db1: %0d pulses at clock %0d code %h down %b, want 1 at 16 code 5 down 1",
                     total, at, code, key_down1);
        end
        pressed = 16'h0000;
    endtask

    initial begin
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'h0, 4'hF, 4'hE, 4'hD};
        reset   = 1'b0;
        pressed = 16'h0000;
        model_reset();
        test_reset();
        test_single_press();
        test_release_and_change();
        test_bounce();
        test_multi_key();
        test_reset_mid();
        test_debounce_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 membrane keypad (PmodKYPD-style, active-low rows with pull-ups) by driving one column low at a time and reading the rows back. It debounces the result over whole scans and reports each new key press as a hex code with a one-clock valid pulse. It is the input-side counterpart of the display anode/segment scanner. It runs on the same slow scan clock and feeds the key code to the datapath, with the display path showing it.

## Interface
- DEBOUNCE_SCANS, 2: consecutive identical full-scan results required before the debounced state changes; legal range 1..7.

- clk_480Hz  input  1  scan clock, all logic on posedge
- reset  input  1  synchronous, active-low; sampled on posedge clk_480Hz
- row  input  4  keypad rows r3..r0, active-low, asynchronous to clk_480Hz
- col  output  4  keypad columns c3..c0, active-low, exactly one bit low at all times
- key_code  output  4  hex code of the last debounced key press
- key_down  output  1  high while a debounced single key is held
- key_valid  output  1  one-clock pulse on each new debounced press

## Operation
- **Key map.** Row r, column c gives these codes:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
  - key_code holds the hex value of the key (for example, r3c1 gives 4'hF).
- **Synchronizer.** row passes through a 2-flop synchronizer (row_s) before any use.
- **Scan FSM.** There are four states, COL0..COL3. col is 1110, 1101, 1011, 0111 respectively.
  - Each state lasts 4 clocks, tracked by a 2-bit phase counter 0..3.
  - At phase 3 the FSM advances COLk to COL(k+1), and COL3 wraps to COL0.
  - There are no other transitions. Unreachable encodings go to COL0 / phase 0.
- **Sampling.** At the edge ending phase 3 of COLk, row_s is captured into a 4-bit slice for column k. Two clocks of settling plus the two synchronizer stages are covered.
- **Scan result.** Evaluated at the edge ending COL3 phase 3, over all 16 captured bits:
  - zero keys pressed: result NONE;
  - exactly one key pressed: result KEY(code);
  - two or more keys pressed: result NONE (no ghost resolution).
- **Debounce.**
  - A 3-bit stable counter compares each scan result with the previous one.
  - If they are equal, the counter increments, saturating at DEBOUNCE_SCANS. Otherwise it is set to 1.
  - When the counter equals DEBOUNCE_SCANS and the result is KEY(k):
    - if key_down=0 or key_code≠k, then key_code←k, key_down←1 and key_valid←1;
    - otherwise nothing changes.
  - When the counter equals DEBOUNCE_SCANS and the result is NONE: key_down←0. key_code holds, and there is no pulse.
  - A direct change from one held key to another (5→6 with no NONE scans in between) produces a new pulse with the new code.
- **key_valid** is high for exactly one clock and is cleared on the following edge.
- **Reset** (reset=0 at a posedge, at any time including mid-scan) has these effects:
  - col=1110, phase=0;
  - key_code=4'h0, key_down=0, key_valid=0;
  - stable counter=0, previous result=NONE;
  - captured slices and synchronizer cleared to all-ones (no key).
  - Scanning restarts at COL0 on the first clock with reset=1.

## Timing
- One full scan takes 16 clocks (33.3 ms at 480 Hz).
- key_valid, key_code and key_down update at the edge ending COL3 phase 3 and are visible while col=1110, phase 0.
- Press latency, for a press stable before the start of a scan: DEBOUNCE_SCANS×16 clocks to the key_valid edge. The worst case is (DEBOUNCE_SCANS+1)×16.
- Release latency to key_down=0: the same bounds.
- col changes only at phase-3 edges and never has two bits low simultaneously.

## Test plan
The bench models the keypad as row[r]=0 iff a key (r,c) is pressed and col[c]=0, combinationally. DEBOUNCE_SCANS=2 unless noted.

1. **Reset and scan sequence.** Hold reset=0 for 3 clocks. Require col=1110, key_code=0, key_down=0 and key_valid=0. Release, then require col cycling 1110 ×4, 1101 ×4, 1011 ×4, 0111 ×4, repeating for 64 clocks.
2. **Single press.** Press '5' (r1c1) at scan start and hold 10 scans. Require exactly one key_valid pulse, at clock 32, with key_code=5 and key_down=1. Require no further pulses.
3. **Release and direct key change.**
   - Release '5': key_down=0 after 2 scans, key_code stays 5, no pulse.
   - Press '5', then switch directly to '6': a second pulse occurs with key_code=6.
4. **Bounce.** Toggle 'D' (r3c3) pressed/released on alternate scans for 5 scans, then hold. Require exactly one pulse, 2 scans after the hold begins, with key_code=D.
5. **Multi-key.** Press '1' and '2' together for 6 scans. Require no pulse and key_down=0. Release '2' and require a pulse with key_code=1.
6. **Reset mid-operation.** Hold '9'. Assert reset=0 during COL2 phase 1. Require reset values on the next edge and the scan restarting at COL0. Require a new pulse with key_code=9 after 32 clocks. Repeat step 2 with DEBOUNCE_SCANS=1 and require the pulse at clock 16.
